// File: rtl/exe_stage_pkg.sv
// Shared execute-stage definitions: ALU command codes, NZCV bit positions
// and the EX/MEM pipeline bundle.
package exe_stage_pkg;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] st_val;
        logic [3:0]  dest;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
    } ex_mem_t;

    // Only arithmetic commands are allowed to touch C and V.
    function automatic logic is_arith(input logic [3:0] cmd);
        return cmd inside {CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC};
    endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU: result plus NZCV; for non-arithmetic commands
// C follows c_in and V reads 0 (the stage keeps the old V).
module alu
    import exe_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  cmd,
    input  logic        c_in,
    output logic [31:0] result,
    output logic [3:0]  nzcv_out
);

    logic [32:0] sum;
    logic        c;
    logic        v;

    always_comb begin
        result = '0;
        sum    = '0;
        c      = c_in;
        v      = 1'b0;
        case (cmd)
            CMD_MOV: result = b;
            CMD_MVN: result = ~b;
            CMD_AND: result = a & b;
            CMD_ORR: result = a | b;
            CMD_EOR: result = a ^ b;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, a} + {1'b0, b};
                if (cmd == CMD_ADC) begin
                    sum = sum + {32'b0, c_in};
                end
                result = sum[31:0];
                c      = sum[32];
                v      = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            CMD_SUB, CMD_SBC: begin
                // a - b - borrow as a + ~b + carry, so C is NOT borrow
                sum = {1'b0, a} + {1'b0, ~b};
                if (cmd == CMD_SUB) begin
                    sum = sum + 33'd1;
                end else begin
                    sum = sum + {32'b0, c_in};
                end
                result = sum[31:0];
                c      = sum[32];
                v      = (a[31] != b[31]) && (sum[31] != a[31]);
            end
            default: result = '0;
        endcase
    end

    assign nzcv_out = {result[31], (result == 32'd0), c, v};

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV status register, branch target adder and the
// EX/MEM pipeline register with flush/freeze control.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic [3:0]  exe_cmd,
    input  logic        s_bit,
    input  logic        wb_en,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        is_branch,
    input  logic [3:0]  dest,
    input  logic [31:0] pc,
    input  logic [31:0] val_rn,
    input  logic [31:0] val2,
    input  logic [31:0] val_rm,
    input  logic [23:0] imm24,
    output logic [31:0] alu_result_o,
    output logic [31:0] st_val_o,
    output logic [3:0]  dest_o,
    output logic        wb_en_o,
    output logic        mem_r_en_o,
    output logic        mem_w_en_o,
    output logic [3:0]  status_o,
    output logic        branch_taken_o,
    output logic [31:0] branch_addr_o
);

    ex_mem_t     ex_mem_d;
    ex_mem_t     ex_mem_q;
    logic [3:0]  status_d;
    logic [3:0]  status_q;
    logic [31:0] alu_res;
    logic [3:0]  alu_nzcv;

    alu u_alu (
        .a        (val_rn),
        .b        (val2),
        .cmd      (exe_cmd),
        .c_in     (status_q[C_BIT]),
        .result   (alu_res),
        .nzcv_out (alu_nzcv)
    );

    always_comb begin
        ex_mem_d = ex_mem_q;
        status_d = status_q;
        if (flush) begin
            ex_mem_d = '0;
        end else if (!freeze) begin
            ex_mem_d.alu_result = alu_res;
            ex_mem_d.st_val     = val_rm;
            ex_mem_d.dest       = dest;
            ex_mem_d.wb_en      = wb_en;
            ex_mem_d.mem_r_en   = mem_r_en;
            ex_mem_d.mem_w_en   = mem_w_en;
            if (s_bit) begin
                status_d[N_BIT] = alu_nzcv[N_BIT];
                status_d[Z_BIT] = alu_nzcv[Z_BIT];
                if (is_arith(exe_cmd)) begin
                    status_d[C_BIT] = alu_nzcv[C_BIT];
                    status_d[V_BIT] = alu_nzcv[V_BIT];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
            status_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            status_q <= status_d;
        end
    end

    assign alu_result_o   = ex_mem_q.alu_result;
    assign st_val_o       = ex_mem_q.st_val;
    assign dest_o         = ex_mem_q.dest;
    assign wb_en_o        = ex_mem_q.wb_en;
    assign mem_r_en_o     = ex_mem_q.mem_r_en;
    assign mem_w_en_o     = ex_mem_q.mem_w_en;
    assign status_o       = status_q;
    assign branch_taken_o = is_branch;
    assign branch_addr_o  = pc + {{6{imm24[23]}}, imm24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases then random ops against an
// arithmetic reference model of the execute stage.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  exe_cmd = '0;
    logic        s_bit = 1'b0;
    logic        wb_en = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic        is_branch = 1'b0;
    logic [3:0]  dest = '0;
    logic [31:0] pc = '0;
    logic [31:0] val_rn = '0;
    logic [31:0] val2 = '0;
    logic [31:0] val_rm = '0;
    logic [23:0] imm24 = '0;
    logic [31:0] alu_result_o;
    logic [31:0] st_val_o;
    logic [3:0]  dest_o;
    logic        wb_en_o;
    logic        mem_r_en_o;
    logic        mem_w_en_o;
    logic [3:0]  status_o;
    logic        branch_taken_o;
    logic [31:0] branch_addr_o;

    int total = 0;
    int bad = 0;

    logic [31:0] m_res, m_st;
    logic [3:0]  m_dest, m_nzcv;
    logic [2:0]  m_ctl;

    exe_stage dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .flush          (flush),
        .exe_cmd        (exe_cmd),
        .s_bit          (s_bit),
        .wb_en          (wb_en),
        .mem_r_en       (mem_r_en),
        .mem_w_en       (mem_w_en),
        .is_branch      (is_branch),
        .dest           (dest),
        .pc             (pc),
        .val_rn         (val_rn),
        .val2           (val2),
        .val_rm         (val_rm),
        .imm24          (imm24),
        .alu_result_o   (alu_result_o),
        .st_val_o       (st_val_o),
        .dest_o         (dest_o),
        .wb_en_o        (wb_en_o),
        .mem_r_en_o     (mem_r_en_o),
        .mem_w_en_o     (mem_w_en_o),
        .status_o       (status_o),
        .branch_taken_o (branch_taken_o),
        .branch_addr_o  (branch_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference ALU from plain 64-bit arithmetic
    task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                           input logic [31:0] b, input logic cin,
                           output logic [31:0] r, output logic c,
                           output logic v, output logic arith);
        longint unsigned ua, ub, s;
        longint sa, sb, ss;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s = 0;
        ss = 0;
        c = 1'b0;
        arith = 1'b1;
        case (cmd)
            4'd2: begin s = ua + ub; ss = sa + sb; c = (s >= 64'h1_0000_0000); end
            4'd3: begin
                s = ua + ub + 64'(cin); ss = sa + sb + longint'(cin);
                c = (s >= 64'h1_0000_0000);
            end
            4'd4: begin s = ua - ub; ss = sa - sb; c = (ua >= ub); end
            4'd5: begin
                s = ua - ub - 64'(!cin); ss = sa - sb - longint'(!cin);
                c = (ua >= ub + 64'(!cin));
            end
            default: arith = 1'b0;
        endcase
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        case (cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            4'd2, 4'd3, 4'd4, 4'd5: r = s[31:0];
            default: r = 32'd0;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_res"}, alu_result_o, m_res);
        chk({tag, "_st"}, st_val_o, m_st);
        chk({tag, "_dest"}, {28'd0, dest_o}, {28'd0, m_dest});
        chk({tag, "_ctl"}, {29'd0, wb_en_o, mem_r_en_o, mem_w_en_o},
            {29'd0, m_ctl});
        chk({tag, "_nzcv"}, {28'd0, status_o}, {28'd0, m_nzcv});
    endtask

    task automatic check_branch(input string tag);
        logic signed [23:0] simm;
        simm = imm24;
        chk({tag, "_btk"}, {31'd0, branch_taken_o}, {31'd0, is_branch});
        chk({tag, "_badr"}, branch_addr_o,
            pc + 32'(longint'(simm) * 4));
    endtask

    // One clock: predict, let the edge happen, compare.
    task automatic step(input string tag);
        logic [31:0] r;
        logic c, v, ar;
        #1;
        check_branch(tag);
        ref_alu(exe_cmd, val_rn, val2, m_nzcv[1], r, c, v, ar);
        @(posedge clk);
        #1;
        if (flush) begin
            m_res = 0; m_st = 0; m_dest = 0; m_ctl = 0;
        end else if (!freeze) begin
            m_res = r;
            m_st = val_rm;
            m_dest = dest;
            m_ctl = {wb_en, mem_r_en, mem_w_en};
            if (s_bit) begin
                m_nzcv[3] = r[31];
                m_nzcv[2] = (r == 0);
                if (ar) m_nzcv[1:0] = {c, v};
            end
        end
        check_all(tag);
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
        exe_cmd = cmd;
        s_bit = s;
        val_rn = a;
        val2 = b;
        val_rm = $urandom;
        dest = 4'($urandom);
        {wb_en, mem_r_en, mem_w_en} = 3'($urandom);
    endtask

    initial begin
        logic [31:0] sv_res;
        logic [3:0] sv_nzcv;
        m_res = 0; m_st = 0; m_dest = 0; m_ctl = 0; m_nzcv = 0;
        set_op(4'd2, 1'b1, 32'd1, 32'd2);
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        set_op(4'd2, 1'b1, 32'h7FFF_FFFF, 32'd1);
        step("add_ovf");
        chk("add_ovf_lit", alu_result_o, 32'h8000_0000);
        chk("add_ovf_nzcv", {28'd0, status_o}, 32'b1001);

        set_op(4'd6, 1'b1, 32'hF0, 32'h0F);
        step("and_keep");
        chk("and_lit", alu_result_o, 32'd0);
        chk("and_nzcv", {28'd0, status_o}, 32'b0101);

        set_op(4'd4, 1'b1, 32'd5, 32'd5);
        step("sub_eq");
        chk("sub_nzcv", {28'd0, status_o}, 32'b0110);

        set_op(4'd3, 1'b0, 32'd1, 32'd1);
        step("adc");
        chk("adc_lit", alu_result_o, 32'd3);

        sv_res = m_res;
        sv_nzcv = m_nzcv;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(4'd2, 1'b1, $urandom, $urandom);
            step("freeze");
        end
        chk("frz_res", alu_result_o, sv_res);
        chk("frz_nzcv", {28'd0, status_o}, {28'd0, sv_nzcv});

        flush = 1'b1;
        set_op(4'd4, 1'b1, 32'd1, 32'd9);
        wb_en = 1'b1;
        step("flush_frz");
        chk("flush_wb", {31'd0, wb_en_o}, 32'd0);
        freeze = 1'b0;
        flush = 1'b0;

        is_branch = 1'b1;
        pc = 32'h100;
        imm24 = 24'hFFFFFE;
        #1;
        chk("br_taken", {31'd0, branch_taken_o}, 32'd1);
        chk("br_addr", branch_addr_o, 32'h0000_00F8);
        is_branch = 1'b0;

        set_op(4'd7, 1'b1, 32'h1234, 32'h8000_0000);
        step("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        m_res = 0; m_st = 0; m_dest = 0; m_ctl = 0; m_nzcv = 0;
        check_all("async_rst");
        #1;
        rst = 1'b0;
        set_op(4'd1, 1'b1, 32'd0, 32'hCAFE_0001);
        step("post_rst");
        chk("post_rst_lit", alu_result_o, 32'hCAFE_0001);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] cmd;
            logic [31:0] a, b;
            cmd = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            set_op(cmd, (cmd >= 4'd1 && cmd <= 4'd9) ? 1'($urandom) : 1'b0, a, b);
            freeze = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 11) == 0);
            is_branch = 1'($urandom);
            pc = $urandom;
            imm24 = 24'($urandom);
            step("rnd");
        end
        freeze = 1'b0;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 freeze  input  1  hazard stall; hold all state.
REQ-004 flush  input  1  insert bubble into EX/MEM register.
REQ-005 exe_cmd  input  4  ALU operation (encoding in REQ-022).
REQ-006 s_bit  input  1  update status flags.
REQ-007 wb_en, mem_r_en, mem_w_en  input  1 each  control bits passed downstream.
REQ-008 is_branch  input  1  instruction is a branch whose condition has passed.
REQ-009 dest  input  4  destination register index.
REQ-010 pc  input  32  PC+4 of the instruction.
REQ-011 val_rn  input  32  first operand.
REQ-012 val2  input  32  second operand, from the shifter/immediate stage.
REQ-013 val_rm  input  32  store data.
REQ-014 imm24  input  24  signed branch offset, in words.
REQ-015 alu_result_o  output  32  registered ALU result.
REQ-016 st_val_o  output  32  registered store data.
REQ-017 dest_o  output  4; wb_en_o, mem_r_en_o, mem_w_en_o  output  1 each; all registered.
REQ-018 status_o  output  4  NZCV (bit 3 = N).
REQ-019 branch_taken_o  output  1  combinational; equals is_branch.
REQ-020 branch_addr_o  output  32  combinational; pc + (sign-extended imm24 << 2), modulo 2^32.

Function
REQ-021 The ALU SHALL be combinational, with result a and flag values computed from val_rn (A), val2 (B) and status C.
REQ-022 Operations SHALL be as follows:
- 0001 MOV: B
- 1001 MVN: ~B
- 0010 ADD/LDR/STR: A+B
- 0011 ADC: A+B+C
- 0100 SUB/CMP: A-B
- 0101 SBC: A-B-!C
- 0110 AND/TST: A&B
- 0111 ORR: A|B
- 1000 EOR: A^B
- Any other code: result 0.
REQ-023 Flag N SHALL equal result[31], and flag Z SHALL equal (result==0).
REQ-024 Arithmetic flags SHALL be computed on 33-bit sums.
- C: carry out for add; NOT borrow for sub.
- V: signed overflow of the 32-bit operation.
REQ-025 Logical ops and MOV/MVN SHALL update N and Z only; C and V retain their previous values.
REQ-026 Status SHALL load the new NZCV on a rising edge when s_bit=1, freeze=0 and flush=0; otherwise it holds.
REQ-027 The EX/MEM register SHALL capture the ALU result, val_rm, dest and the control bits on each rising edge when freeze=0, giving 1-cycle latency.
REQ-028 When flush=1, the EX/MEM register SHALL load a bubble: wb_en_o, mem_r_en_o and mem_w_en_o = 0, all other fields 0, status unchanged.
REQ-029 Priority SHALL be rst > flush > freeze.
REQ-030 When freeze=1 and flush=0, all registered outputs and the status SHALL hold.
REQ-031 Branch outputs SHALL be independent of freeze and flush.

Reset
REQ-032 Asserting rst SHALL immediately clear all registered outputs and status_o to 0, regardless of clk.
REQ-033 After rst deasserts, the first capture SHALL occur on the next rising edge.

Structure
REQ-034 The exe_cmd codes and the NZCV bit positions SHALL live in the shared package used by the decode stage.
REQ-035 The ALU SHALL be a separate combinational sub-module named alu (ports a, b, cmd, c_in, result, nzcv_out).
REQ-036 The implementation SHALL be 120-400 lines.

Verification
REQ-037 ADD 0x7FFFFFFF + 1 with s_bit=1 -> alu_result_o = 0x80000000 next cycle; status = N1 Z0 C0 V1.
REQ-038 SUB 5 - 5 with s_bit=1 -> result 0; status = N0 Z1 C1 V0. Then ADC 1+1 -> result 3.
REQ-039 AND 0xF0 & 0x0F with s_bit=1 after the REQ-037 state -> result 0; status = N0 Z1; C0 V1 retained.
REQ-040 freeze=1 for 3 cycles while inputs change -> outputs and status unchanged. flush=1 together with freeze=1 -> bubble loaded.
REQ-041 is_branch=1, pc=0x100, imm24=0xFFFFFE -> branch_taken_o=1, branch_addr_o=0xF8 in the same cycle.
REQ-042 rst pulsed between clock edges during a stream of ops -> all outputs 0 immediately; a valid op in the first cycle after release appears one cycle later.
